// File: rtl/mem_pkg.sv
// Shared memory-stage control types used by the core and its memory-side peripherals.
package mem_pkg;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic [2:0] funct3;
    } mem_ctrl_t;

    localparam logic [2:0] MEM_FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/vga_pkg.sv
// Types and address map for the VGA double-buffer swap scheduler.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        CLEAR = 2'd2
    } vga_sched_state_t;

    localparam logic [31:0] VGA_SWAP_ADDR   = 32'h1003_0000;
    localparam logic [31:0] VGA_FB_BASE     = 32'h1002_0000;
    localparam int unsigned VGA_FRAME_W     = 160;
    localparam int unsigned VGA_FRAME_H     = 120;
    localparam logic [31:0] VGA_CLEAR_COLOR = 32'h0;

endpackage

// File: rtl/vga_swap_sched_if.sv
// Store bus between the core's MEM stage, the swap scheduler and the VGA frame-memory write port.
interface vga_swap_sched_if;
    import mem_pkg::*;

    logic [31:0] i_pxlAddr;
    logic [31:0] i_pxlData;
    mem_ctrl_t   i_ctrlVGA;
    logic        en_MEM;
    logic        o_stall;
    logic [31:0] o_pxlAddr;
    logic [31:0] o_pxlData;
    mem_ctrl_t   o_ctrlVGA;

    // master: core MEM stage plus frame memory; slave: the scheduler
    modport master (
        output i_pxlAddr, i_pxlData, i_ctrlVGA, en_MEM,
        input  o_stall, o_pxlAddr, o_pxlData, o_ctrlVGA
    );

    modport slave (
        input  i_pxlAddr, i_pxlData, i_ctrlVGA, en_MEM,
        output o_stall, o_pxlAddr, o_pxlData, o_ctrlVGA
    );

endinterface

// File: rtl/vga_vblank_sync.sv
// Brings the asynchronous vblank level into i_clk and emits a one-cycle rising-edge pulse.
module vga_vblank_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_vblank,
    output logic o_vb_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = i_vblank;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_vb_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/vga_swap_sched.sv
// Front/back framebuffer swap scheduler: arms on a SWAP_ADDR store, commits on the next vblank edge.
// Optional VGA_AUTOCLEAR_EN: after each commit, fill the new back buffer with CLEAR_COLOR.
module vga_swap_sched
    import mem_pkg::*;
    import vga_pkg::*;
#(
    parameter logic [31:0] SWAP_ADDR   = VGA_SWAP_ADDR
`ifdef VGA_AUTOCLEAR_EN
    ,
    parameter int unsigned FRAME_W     = VGA_FRAME_W,
    parameter int unsigned FRAME_H     = VGA_FRAME_H,
    parameter logic [31:0] FB_BASE     = VGA_FB_BASE,
    parameter logic [31:0] CLEAR_COLOR = VGA_CLEAR_COLOR
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    vga_swap_sched_if.slave   bus,
    input  logic              i_vblank,
    output logic              o_buffer_select,
    output logic              o_swap_done,
    output logic [15:0]       o_frame_cnt
);

`ifdef VGA_AUTOCLEAR_EN
    localparam logic [14:0] LAST_PIX = 15'(FRAME_W * FRAME_H - 1);
`endif

    vga_sched_state_t state_q, state_d;
    logic             buf_sel_q, buf_sel_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             swap_done_q, swap_done_d;
`ifdef VGA_AUTOCLEAR_EN
    logic [14:0]      clr_cnt_q, clr_cnt_d;
`endif

    logic req;
    logic swreq;
    logic vb_rise;

    vga_vblank_sync u_vblank_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_vblank  (i_vblank),
        .o_vb_rise (vb_rise)
    );

    assign req   = bus.en_MEM & bus.i_ctrlVGA.memWrite;
    assign swreq = req & (bus.i_pxlAddr == SWAP_ADDR);

    always_comb begin
        state_d       = state_q;
        buf_sel_d     = buf_sel_q;
        frame_cnt_d   = frame_cnt_q;
        swap_done_d   = 1'b0;
`ifdef VGA_AUTOCLEAR_EN
        clr_cnt_d     = clr_cnt_q;
`endif
        bus.o_stall   = 1'b0;
        bus.o_pxlAddr = '0;
        bus.o_pxlData = '0;
        bus.o_ctrlVGA = '0;

        case (state_q)
            IDLE: begin
                if (swreq) begin
                    state_d = PEND;
                end else if (req && i_reset_n) begin
                    // reset gating keeps the write port quiet while the core is held in reset
                    bus.o_pxlAddr = bus.i_pxlAddr;
                    bus.o_pxlData = bus.i_pxlData;
                    bus.o_ctrlVGA = bus.i_ctrlVGA;
                end
            end
            PEND: begin
                bus.o_stall = bus.en_MEM;
                if (vb_rise) begin
                    buf_sel_d   = ~buf_sel_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    swap_done_d = 1'b1;
`ifdef VGA_AUTOCLEAR_EN
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
`else
                    state_d     = IDLE;
`endif
                end
            end
`ifdef VGA_AUTOCLEAR_EN
            CLEAR: begin
                bus.o_stall                = 1'b1;
                bus.o_pxlAddr              = FB_BASE + {15'b0, clr_cnt_q, 2'b00};
                bus.o_pxlData              = CLEAR_COLOR;
                bus.o_ctrlVGA.memWrite     = 1'b1;
                bus.o_ctrlVGA.funct3       = MEM_FUNCT3_WORD;
                if (clr_cnt_q == LAST_PIX) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 15'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            buf_sel_q   <= 1'b0;
            frame_cnt_q <= '0;
            swap_done_q <= 1'b0;
`ifdef VGA_AUTOCLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_sel_q   <= buf_sel_d;
            frame_cnt_q <= frame_cnt_d;
            swap_done_q <= swap_done_d;
`ifdef VGA_AUTOCLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

    assign o_buffer_select = buf_sel_q;
    assign o_swap_done     = swap_done_q;
    assign o_frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_vga_swap_sched.sv
// Directed bench for vga_swap_sched: reset, swap timing, vblank corner cases, wrap, optional auto-clear.
module tb_vga_swap_sched;
    import mem_pkg::*;
    import vga_pkg::*;

    localparam logic [31:0] FB = 32'h1002_0000;
    localparam logic [31:0] SW = 32'h1003_0000;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        vblank = 1'b0;
    logic        buf_sel;
    logic        swap_done;
    logic [15:0] frame_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned bad   = 0;

    vga_swap_sched_if bus ();

    vga_swap_sched dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .bus             (bus),
        .i_vblank        (vblank),
        .o_buffer_select (buf_sel),
        .o_swap_done     (swap_done),
        .o_frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.en_MEM    = 1'b0;
        bus.i_pxlAddr = '0;
        bus.i_pxlData = '0;
        bus.i_ctrlVGA = '0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        bus.en_MEM             = 1'b1;
        bus.i_pxlAddr          = a;
        bus.i_pxlData          = d;
        bus.i_ctrlVGA          = '0;
        bus.i_ctrlVGA.memWrite = 1'b1;
        bus.i_ctrlVGA.funct3   = 3'b010;
    endtask

    // advance to 1 time unit after the n-th following falling edge
    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        drive_idle();
        step(3);
        expect_eq("rst_buf",   32'(buf_sel), 32'd0);
        expect_eq("rst_cnt",   32'(frame_cnt), 32'd0);
        expect_eq("rst_done",  32'(swap_done), 32'd0);
        expect_eq("rst_stall", 32'(bus.o_stall), 32'd0);
        expect_eq("rst_ctrl",  {27'b0, bus.o_ctrlVGA}, 32'd0);
        rst_n = 1'b1;

        // basic swap: arm, stall, commit three edges after vblank rises
        step(1);
        drive_store(SW, 32'hDEAD_BEEF); #1;
        expect_eq("t1_arm_stall", 32'(bus.o_stall), 32'd0);
        expect_eq("t1_arm_ctrl",  {27'b0, bus.o_ctrlVGA}, 32'd0);
        step(1);
        drive_store(FB + 32'd8, 32'h0000_00AB); #1;
        expect_eq("t1_pend_stall", 32'(bus.o_stall), 32'd1);
        expect_eq("t1_pend_ctrl",  {27'b0, bus.o_ctrlVGA}, 32'd0);
        step(9);
        vblank = 1'b1;
        step(1);
        expect_eq("t1_e1_buf", 32'(buf_sel), 32'd0);
        step(1);
        expect_eq("t1_e2_buf",   32'(buf_sel), 32'd0);
        expect_eq("t1_e2_stall", 32'(bus.o_stall), 32'd1);
        step(1);
        expect_eq("t1_commit_buf",  32'(buf_sel), 32'd1);
        expect_eq("t1_commit_done", 32'(swap_done), 32'd1);
        expect_eq("t1_commit_cnt",  32'(frame_cnt), 32'd1);
`ifdef VGA_AUTOCLEAR_EN
        bad = 0;
        for (int unsigned i = 0; i < 19200; i++) begin
            if (bus.o_stall !== 1'b1 || bus.o_ctrlVGA.memWrite !== 1'b1 ||
                bus.o_pxlAddr !== FB + 4 * i || bus.o_pxlData !== 32'h0)
                bad++;
            step(1);
        end
        expect_eq("ac_fill_bad", bad, 32'd0);
`endif
        expect_eq("t1_post_stall", 32'(bus.o_stall), 32'd0);
        expect_eq("t1_post_we",    32'(bus.o_ctrlVGA.memWrite), 32'd1);
        expect_eq("t1_post_addr",  bus.o_pxlAddr, FB + 32'd8);
        expect_eq("t1_post_data",  bus.o_pxlData, 32'h0000_00AB);
        drive_idle();
        step(1);
        expect_eq("t1_done_pulse", 32'(swap_done), 32'd0);

`ifdef VGA_AUTOCLEAR_EN
        // reset during the fill stops the writes at once
        vblank = 1'b0;
        step(4);
        drive_store(SW, 32'h0); #1;
        step(1);
        drive_idle();
        vblank = 1'b1;
        step(3);
        expect_eq("ac_commit_buf", 32'(buf_sel), 32'd0);
        expect_eq("ac_commit_cnt", 32'(frame_cnt), 32'd2);
        step(100);
        expect_eq("ac_mid_addr",  bus.o_pxlAddr, FB + 32'd400);
        expect_eq("ac_mid_stall", 32'(bus.o_stall), 32'd1);
        rst_n = 1'b0; #1;
        expect_eq("ac_rst_ctrl",  {27'b0, bus.o_ctrlVGA}, 32'd0);
        expect_eq("ac_rst_stall", 32'(bus.o_stall), 32'd0);
        expect_eq("ac_rst_addr",  bus.o_pxlAddr, 32'd0);
        step(1);
        rst_n = 1'b1;
`else
        // vblank already high when armed: wait for a fresh rising edge
        step(1);
        drive_store(SW, 32'h0); #1;
        step(1);
        drive_store(FB + 32'd12, 32'h1); #1;
        expect_eq("t2_stall", 32'(bus.o_stall), 32'd1);
        step(5);
        expect_eq("t2_hold_buf", 32'(buf_sel), 32'd1);
        expect_eq("t2_hold_cnt", 32'(frame_cnt), 32'd1);
        vblank = 1'b0;
        step(4);
        expect_eq("t2_fall_buf", 32'(buf_sel), 32'd1);
        vblank = 1'b1;
        step(2);
        expect_eq("t2_e2_buf", 32'(buf_sel), 32'd1);
        step(1);
        expect_eq("t2_commit_buf",  32'(buf_sel), 32'd0);
        expect_eq("t2_commit_cnt",  32'(frame_cnt), 32'd2);
        expect_eq("t2_commit_done", 32'(swap_done), 32'd1);
        drive_idle();

        // repeated swap store while pending: stalled, one commit only
        vblank = 1'b0;
        step(4);
        drive_store(SW, 32'h0); #1;
        step(1);
        drive_store(SW, 32'h0); #1;
        expect_eq("t3_dup_stall", 32'(bus.o_stall), 32'd1);
        expect_eq("t3_dup_ctrl",  {27'b0, bus.o_ctrlVGA}, 32'd0);
        step(3);
        expect_eq("t3_dup_cnt", 32'(frame_cnt), 32'd2);
        drive_idle(); #1;
        expect_eq("t3_noen_stall", 32'(bus.o_stall), 32'd0);
        vblank = 1'b1;
        step(3);
        expect_eq("t3_commit_buf",  32'(buf_sel), 32'd1);
        expect_eq("t3_commit_cnt",  32'(frame_cnt), 32'd3);
        expect_eq("t3_commit_done", 32'(swap_done), 32'd1);
        vblank = 1'b0;
        step(3);
        vblank = 1'b1;
        step(4);
        expect_eq("t3_norearm_buf", 32'(buf_sel), 32'd1);
        expect_eq("t3_norearm_cnt", 32'(frame_cnt), 32'd3);

        // swap store in the same cycle as the edge pulse: arms only
        vblank = 1'b0;
        step(4);
        vblank = 1'b1;
        step(2);
        drive_store(SW, 32'h0); #1;
        expect_eq("t4_arm_ctrl", {27'b0, bus.o_ctrlVGA}, 32'd0);
        step(1);
        drive_idle(); #1;
        expect_eq("t4_arm_buf",  32'(buf_sel), 32'd1);
        expect_eq("t4_arm_done", 32'(swap_done), 32'd0);
        step(3);
        expect_eq("t4_wait_cnt", 32'(frame_cnt), 32'd3);
        vblank = 1'b0;
        step(3);
        vblank = 1'b1;
        step(3);
        expect_eq("t4_commit_buf", 32'(buf_sel), 32'd0);
        expect_eq("t4_commit_cnt", 32'(frame_cnt), 32'd4);

        // reset while pending discards the swap
        vblank = 1'b0;
        step(4);
        drive_store(SW, 32'h0); #1;
        step(1);
        drive_store(FB + 32'd8, 32'h55); #1;
        expect_eq("t5_pend_stall", 32'(bus.o_stall), 32'd1);
        rst_n = 1'b0; #1;
        expect_eq("t5_rst_stall", 32'(bus.o_stall), 32'd0);
        expect_eq("t5_rst_ctrl",  {27'b0, bus.o_ctrlVGA}, 32'd0);
        expect_eq("t5_rst_addr",  bus.o_pxlAddr, 32'd0);
        expect_eq("t5_rst_data",  bus.o_pxlData, 32'd0);
        expect_eq("t5_rst_cnt",   32'(frame_cnt), 32'd0);
        expect_eq("t5_rst_done",  32'(swap_done), 32'd0);
        step(1);
        rst_n = 1'b1; #1;
        expect_eq("t5_fwd_we",    32'(bus.o_ctrlVGA.memWrite), 32'd1);
        expect_eq("t5_fwd_addr",  bus.o_pxlAddr, FB + 32'd8);
        expect_eq("t5_fwd_data",  bus.o_pxlData, 32'h55);
        expect_eq("t5_fwd_stall", 32'(bus.o_stall), 32'd0);
        drive_idle();
        vblank = 1'b1;
        step(4);
        expect_eq("t5_nocommit_buf", 32'(buf_sel), 32'd0);
        expect_eq("t5_nocommit_cnt", 32'(frame_cnt), 32'd0);

        // frame counter wrap from 16'hFFFF
        vblank = 1'b0;
        step(4);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        #1;
        expect_eq("t6_preload", 32'(frame_cnt), 32'h0000_FFFF);
        drive_store(SW, 32'h0); #1;
        step(1);
        drive_idle();
        vblank = 1'b1;
        step(3);
        expect_eq("t6_wrap_cnt",  32'(frame_cnt), 32'd0);
        expect_eq("t6_wrap_buf",  32'(buf_sel), 32'd1);
        expect_eq("t6_wrap_done", 32'(swap_done), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
